// File: rtl/cgra_cfg_pkg.sv
// Shared types and defaults for the CGRA tile configuration sender.
// CFG_PARITY_EN: appends an even-parity bit to each config word.
package cgra_cfg_pkg;

   localparam int unsigned NTILES = 4;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned OPT_W  = 59;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned TID_W  = (NTILES > 1) ? $clog2(NTILES) : 1;
`ifdef CFG_PARITY_EN
   localparam int unsigned PAR_W  = 1;
`else
   localparam int unsigned PAR_W  = 0;
`endif
   localparam int unsigned CFG_W  = 1 + TID_W + ADDR_W + OPT_W + PAR_W;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   // Field order from MSB: bcast, tid, addr, opt[, parity].
   typedef struct packed {
      logic              bcast;
      logic [TID_W-1:0]  tid;
      logic [ADDR_W-1:0] addr;
      logic [OPT_W-1:0]  opt;
`ifdef CFG_PARITY_EN
      logic              parity;
`endif
   } cfg_msg_t;

   // Even-parity bit over every field except the parity bit itself.
   function automatic logic cfg_parity(cfg_msg_t m);
      return ^{m.bcast, m.tid, m.addr, m.opt};
   endfunction

endpackage

// File: rtl/cgra_cfg_sender_if.sv
// Config stream input and per-tile waddr/wopt write ports of the sender.
// master: the sender; slave: the config loader plus the mesh it feeds.
interface cgra_cfg_sender_if #(
   parameter int unsigned NTILES = cgra_cfg_pkg::NTILES,
   parameter int unsigned ADDR_W = cgra_cfg_pkg::ADDR_W,
   parameter int unsigned OPT_W  = cgra_cfg_pkg::OPT_W,
   parameter int unsigned CFG_W  = cgra_cfg_pkg::CFG_W
);

   logic                     recv_cfg__en;
   logic [CFG_W-1:0]         recv_cfg__msg;
   logic                     recv_cfg__rdy;
   logic [NTILES-1:0]        send_waddr__en;
   logic [NTILES*ADDR_W-1:0] send_waddr__msg;
   logic [NTILES-1:0]        send_waddr__rdy;
   logic [NTILES-1:0]        send_wopt__en;
   logic [NTILES*OPT_W-1:0]  send_wopt__msg;
   logic [NTILES-1:0]        send_wopt__rdy;

   modport master (
      input  recv_cfg__en, recv_cfg__msg,
      output recv_cfg__rdy,
      output send_waddr__en, send_waddr__msg,
      input  send_waddr__rdy,
      output send_wopt__en, send_wopt__msg,
      input  send_wopt__rdy
   );

   modport slave (
      output recv_cfg__en, recv_cfg__msg,
      input  recv_cfg__rdy,
      input  send_waddr__en, send_waddr__msg,
      output send_waddr__rdy,
      input  send_wopt__en, send_wopt__msg,
      output send_wopt__rdy
   );

endinterface

// File: rtl/cgra_cfg_fifo.sv
// Two-entry FIFO; push and pop may happen in the same cycle, including when full.
module cgra_cfg_fifo #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [Width-1:0] mem_q [2];
   logic             wptr_q;
   logic             rptr_q;
   logic [1:0]       cnt_q;

   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);
   assign rdata = mem_q[rptr_q];

   // Storage, pointers and occupancy; caller never pushes full without popping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= ~wptr_q;
         end
         if (pop) rptr_q <= ~rptr_q;
         if (push && !pop)      cnt_q <= cnt_q + 2'd1;
         else if (pop && !push) cnt_q <= cnt_q - 2'd1;
      end
   end

endmodule

// File: rtl/cgra_cfg_sender.sv
// Buffers config words and issues each to one tile (or all tiles) in a single
// all-or-nothing cycle, then signals session completion.
// CFG_PARITY_EN: words failing the even-parity check are dropped and counted.
module cgra_cfg_sender #(
   parameter int unsigned NTILES = cgra_cfg_pkg::NTILES,
   parameter int unsigned ADDR_W = cgra_cfg_pkg::ADDR_W,
   parameter int unsigned OPT_W  = cgra_cfg_pkg::OPT_W,
   parameter int unsigned CNT_W  = cgra_cfg_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_total,
   cgra_cfg_sender_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sent_cnt
`ifdef CFG_PARITY_EN
   ,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   import cgra_cfg_pkg::*;

   localparam int unsigned TW = (NTILES > 1) ? $clog2(NTILES) : 1;
`ifdef CFG_PARITY_EN
   localparam int unsigned PW = 1;
`else
   localparam int unsigned PW = 0;
`endif
   localparam int unsigned CW = 1 + TW + ADDR_W + OPT_W + PW;

   state_t            state_q;
   logic [CNT_W-1:0]  total_q, acc_cnt_q, err_q, sent_d, err_d;
   logic [CNT_W:0]    fin_sum;
   logic [CW-1:0]     head;
   logic              fifo_full, fifo_empty, push, pop, issue, drop, bad_par, tgt_ok;
   logic [NTILES-1:0] tgt;
   logic              h_bcast;
   logic [TW-1:0]     h_tid;
   logic [ADDR_W-1:0] h_addr;
   logic [OPT_W-1:0]  h_opt;

   assign h_bcast = head[CW-1];
   assign h_tid   = head[CW-2 -: TW];
   assign h_addr  = head[PW+OPT_W +: ADDR_W];
   assign h_opt   = head[PW +: OPT_W];

   assign bus.recv_cfg__rdy = (state_q == StRun) && !fifo_full && (acc_cnt_q < total_q);
   assign push              = bus.recv_cfg__en && bus.recv_cfg__rdy;

   cgra_cfg_fifo #(
      .Width (CW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (bus.recv_cfg__msg),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Issue decision for the FIFO head and the per-tile write ports.
   always_comb begin
      tgt = '0;
      if (h_bcast)                    tgt = '1;
      else if (32'(h_tid) < NTILES)   tgt[h_tid] = 1'b1;
      drop    = !h_bcast && !(32'(h_tid) < NTILES);
`ifdef CFG_PARITY_EN
      bad_par = ^head;
`else
      bad_par = 1'b0;
`endif
      tgt_ok  = &(~tgt | (bus.send_waddr__rdy & bus.send_wopt__rdy));
      // Dropped words leave without waiting on any tile.
      pop     = !fifo_empty && (drop || bad_par || tgt_ok);
      issue   = !fifo_empty && !drop && !bad_par && tgt_ok;
      bus.send_waddr__en  = issue ? tgt : '0;
      bus.send_wopt__en   = issue ? tgt : '0;
      bus.send_waddr__msg = '0;
      bus.send_wopt__msg  = '0;
      for (int unsigned i = 0; i < NTILES; i++) begin
         if (issue && tgt[i]) begin
            bus.send_waddr__msg[i*ADDR_W +: ADDR_W] = h_addr;
            bus.send_wopt__msg[i*OPT_W +: OPT_W]    = h_opt;
         end
      end
   end

   // Next-state word counters; completion compares their sum against the total.
   always_comb begin
      sent_d = sent_cnt;
      err_d  = err_q;
      if (pop) begin
         if (bad_par) err_d  = err_q + 1'b1;
         else         sent_d = sent_cnt + 1'b1;
      end
      fin_sum = {1'b0, sent_d} + {1'b0, err_d};
   end

   // Session FSM with registered busy/done and counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         total_q   <= '0;
         acc_cnt_q <= '0;
         sent_cnt  <= '0;
         err_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  total_q   <= cfg_total;
                  acc_cnt_q <= '0;
                  sent_cnt  <= '0;
                  err_q     <= '0;
                  busy      <= 1'b1;
                  if (cfg_total == '0) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (push) acc_cnt_q <= acc_cnt_q + 1'b1;
               sent_cnt <= sent_d;
               err_q    <= err_d;
               if (fin_sum == {1'b0, total_q}) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef CFG_PARITY_EN
   assign err_cnt = err_q;
`endif

endmodule
